// File: rtl/edge_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : edge_event_logger
// Brief    : Sampled rise/fall detector that timestamps edges into a FIFO.
// Revision : 1.0
// ============================================================================
module edge_event_logger #(
    parameter int TS_WIDTH = 16,
    parameter int DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       a_in,
    input  logic                       enable,
    input  logic [1:0]                 edge_sel,
    input  logic                       clear,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic                       ev_fell,
    output logic [TS_WIDTH-1:0]        ev_time,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic                a_past_q;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     fill_q, fill_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          drop_q, drop_d;
    logic [TS_WIDTH:0]   mem_q [DEPTH];

    logic is_rise, is_fall, push_req, pop_req, is_full, do_push, do_pop, do_drop;

    assign is_rise  = ~a_past_q & a_in;
    assign is_fall  = a_past_q & ~a_in;
    assign push_req = ~clear & enable & ((is_rise & edge_sel[1]) | (is_fall & edge_sel[0]));
    assign pop_req  = ~clear & ev_ready & (fill_q != '0);
    assign is_full  = (fill_q == DEPTH[ADDR_W:0]);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push  = push_req & (~is_full | pop_req);
    assign do_pop   = pop_req;
    assign do_drop  = push_req & is_full & ~pop_req;

    always_comb begin
        ts_d       = ts_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clear) begin
            ts_d       = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fill_d     = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (enable) begin
                ts_d = ts_q + 1'b1;
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   fill_d = fill_q + 1'b1;
                2'b01:   fill_d = fill_q - 1'b1;
                default: fill_d = fill_q;
            endcase
            if (do_drop) begin
                overflow_d = 1'b1;
                if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_past_q   <= 1'b0;
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            a_past_q   <= a_in;
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= {is_fall, ts_q};
            end
        end
    end

    assign ev_valid   = (fill_q != '0);
    assign ev_fell    = mem_q[rd_ptr_q][TS_WIDTH];
    assign ev_time    = mem_q[rd_ptr_q][TS_WIDTH-1:0];
    assign fill       = fill_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_event_logger
// Brief    : Directed plus randomized bench against a queue-based event model.
// Revision : 1.0
// ============================================================================
module tb_edge_event_logger;

    localparam int TSW   = 6;
    localparam int DEPTH = 8;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b0;
    logic           a_in     = 1'b0;
    logic           enable   = 1'b0;
    logic [1:0]     edge_sel = 2'b00;
    logic           clear    = 1'b0;
    logic           ev_ready = 1'b0;
    logic           ev_valid;
    logic           ev_fell;
    logic [TSW-1:0] ev_time;
    logic [FW-1:0]  fill;
    logic           overflow;
    logic [7:0]     drop_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit fell;
        int t;
    } ev_t;

    ev_t q[$];
    bit  m_past;
    int  m_ts;
    bit  m_ovf;
    int  m_drops;

    edge_event_logger #(
        .TS_WIDTH (TSW),
        .DEPTH    (DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_in       (a_in),
        .enable     (enable),
        .edge_sel   (edge_sel),
        .clear      (clear),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_fell    (ev_fell),
        .ev_time    (ev_time),
        .fill       (fill),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_past  = 1'b0;
        m_ts    = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    // Applies one sampling edge's worth of behaviour using the inputs the DUT just saw.
    task automatic model_edge();
        bit   pop, push, fell, was_full;
        pop      = !clear && ev_ready && (q.size() > 0);
        fell     = m_past && !a_in;
        push     = !clear && enable &&
                   ((!m_past && a_in && edge_sel[1]) || (fell && edge_sel[0]));
        was_full = (q.size() == DEPTH);
        if (clear) begin
            q.delete();
            m_ts    = 0;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                if (was_full && !pop) begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end else begin
                    q.push_back('{fell: fell, t: m_ts});
                end
            end
            if (enable) m_ts = (m_ts + 1) % (1 << TSW);
        end
        m_past = a_in;
    endtask

    task automatic check_outputs();
        chk("valid", ev_valid, q.size() != 0);
        chk("fill", fill, q.size());
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, m_drops);
        if (q.size() != 0) begin
            chk("head_fell", ev_fell, q[0].fell);
            chk("head_time", ev_time, q[0].t);
        end
    endtask

    task automatic cycle(input bit a, input bit en, input bit [1:0] sel,
                         input bit clr, input bit rdy);
        a_in     = a;
        enable   = en;
        edge_sel = sel;
        clear    = clr;
        ev_ready = rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    logic [9:0] pat;
    bit         a_cur;
    int         rdy_pct;

    initial begin
        pat = 10'b1101111110;
        #2;
        chk("rst_valid", ev_valid, 0);
        chk("rst_fill", fill, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drops", drop_count, 0);
        chk("rst_time", ev_time, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Falls only
        for (int i = 0; i < 10; i++) cycle(pat[i], 1'b1, 2'b01, 1'b0, 1'b0);
        chk("falls_fill", fill, 1);
        chk("falls_fell", ev_fell, 1);
        chk("falls_time", ev_time, 7);

        // Rises and falls with a consumer that is always ready
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(pat[i], 1'b1, 2'b11, 1'b0, 1'b1);
            if (i == 1) begin
                chk("both_e1_fell", ev_fell, 0);
                chk("both_e1_time", ev_time, 1);
            end
            if (i == 7) begin
                chk("both_e7_fell", ev_fell, 1);
                chk("both_e7_time", ev_time, 7);
            end
            if (i == 8) begin
                chk("both_e8_fell", ev_fell, 0);
                chk("both_e8_time", ev_time, 8);
            end
        end

        // Overflow then clear
        do_reset();
        for (int i = 0; i < 10; i++) cycle(i % 2 == 0, 1'b1, 2'b11, 1'b0, 1'b0);
        chk("ovf_fill", fill, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drops", drop_count, 2);
        cycle(1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
        chk("clr_fill", fill, 0);
        chk("clr_flag", overflow, 0);
        chk("clr_drops", drop_count, 0);
        chk("clr_valid", ev_valid, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) cycle(i % 2 == 0, 1'b1, 2'b11, 1'b0, 1'b0);
        chk("full_fill", fill, 8);
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
        chk("fullpp_fill", fill, 8);
        chk("fullpp_drops", drop_count, 0);

        // Fall while disabled is not logged and the timestamp freezes
        do_reset();
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
        chk("en_nofill", fill, 0);
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        chk("en_time", ev_time, 6);

        // Asynchronous reset with queued events
        do_reset();
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        chk("arst_pre_fill", fill, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", ev_valid, 0);
        chk("arst_fill", fill, 0);
        model_reset();
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        chk("arst_rise_fell", ev_fell, 0);
        chk("arst_rise_time", ev_time, 0);

        // Randomized traffic with varying consumer pressure
        a_cur   = 1'b1;
        rdy_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rdy_pct = $urandom_range(0, 100);
            if ($urandom_range(0, 99) < 35) a_cur = ~a_cur;
            cycle(a_cur,
                  $urandom_range(0, 9) != 0,
                  2'($urandom_range(0, 3)),
                  $urandom_range(0, 79) == 0,
                  $urandom_range(0, 99) < rdy_pct);
            if ($urandom_range(0, 399) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rnd_arst_fill", fill, 0);
                model_reset();
                #1;
                rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/edge_event_logger.md
# edge_event_logger

Synthesizable sampled-edge monitor that sits directly downstream of a single-bit stimulus or control signal. It gives hardware the same rise and fall event information that `$rose`/`$fell` concurrent assertions give in simulation. On every `clk` rising edge it compares the sampled input with its previous sample, and timestamps each selected edge with a free-running cycle counter. Events are queued in a small FIFO that a consumer drains over a valid/ready handshake.

## Interface
Parameters:
- `TS_WIDTH`, 16: width of the cycle timestamp counter and `ev_time`.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.

Ports:
- `clk`, in, 1: single clock; all sampling on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `a_in`, in, 1: monitored signal; synchronous to `clk` (no synchronizer inside).
- `enable`, in, 1: 1 = detect events and advance the timestamp counter.
- `edge_sel`, in, 2: bit0 = log falls, bit1 = log rises; 00 logs nothing.
- `clear`, in, 1: synchronous flush of FIFO, counters and flags.
- `ev_valid`, out, 1: FIFO head holds an event.
- `ev_ready`, in, 1: consumer accepts the head when `ev_valid & ev_ready`.
- `ev_fell`, out, 1: head event type; 1 = fall (1→0), 0 = rise (0→1).
- `ev_time`, out, TS_WIDTH: timestamp of the head event.
- `fill`, out, $clog2(DEPTH)+1: current number of stored entries.
- `overflow`, out, 1: sticky; set when an event was dropped.
- `drop_count`, out, 8: number of dropped events, saturating at 255.

## Operation
- Past-value register `a_past` loads `a_in` on every `clk` edge, regardless of `enable`.
- `a_past` resets to 0, matching SVA default-past semantics. If `a_in` = 1 at the first edge after reset, that edge is a rise.
- Fall at edge N: `a_past` = 1 and the sampled `a_in` = 0. Rise at edge N: `a_past` = 0 and the sampled `a_in` = 1.
- An event is pushed when `enable` = 1 and the matching `edge_sel` bit = 1. At most one event can occur per cycle.
- Timestamp counter `ts`:
  - Resets to 0.
  - Increments by 1 per edge while `enable` = 1 and holds otherwise.
  - Wraps modulo 2^TS_WIDTH with no flag.
- Pushed entry = {fell, `ts` value before this edge's increment}.
- FIFO is a circular buffer with read and write pointers; `fill` counts entries from 0 to DEPTH.
- Pop occurs when `ev_valid & ev_ready`. `ev_fell` and `ev_time` must be ignored while `ev_valid` = 0.
- Push while full with no simultaneous pop: the event is dropped, `overflow` is set to 1, and `drop_count` increments (saturating at 255).
- Push and pop in the same cycle while full: both are performed, nothing is dropped, and `fill` stays at DEPTH.
- Push and pop in the same cycle while empty: no bypass. The pop is ignored because `ev_valid` = 0; the push is stored.
- `clear` = 1:
  - Empties the FIFO.
  - Sets `ts` to 0, `overflow` to 0 and `drop_count` to 0.
  - Suppresses any push and pop in that cycle.
  - `a_past` still updates.
- Reset values: `ev_valid` 0, `fill` 0, `overflow` 0, `drop_count` 0, `ts` 0, `a_past` 0, pointers 0. `ev_fell` and `ev_time` are don't-care but must be reset to 0 so they never go X.
- Reset asserted mid-operation discards all queued events immediately (asynchronously).

## Timing
- Detection latency: an edge of `a_in` sampled at `clk` edge N appears as `ev_valid` = 1 after edge N, i.e. in cycle N+1, when the FIFO was empty.
- Outputs are registered or come straight from FIFO storage; there is no combinational path from `a_in` to any output.
- `ev_valid` depends only on `fill`. It must not depend combinationally on `ev_ready`.
- Throughput: one push and one pop per cycle sustained.
- Changes to `edge_sel` and `enable` take effect at the next sampling edge.

## Test plan
- Falls only (`edge_sel` = 01, `enable` = 1), `a_in` driven 0,1,1,1,1,1,1,0,1,1 on edges 0..9 → exactly one event: `ev_fell` = 1, `ev_time` = 7. No event at edge 1 (rise).
- Rises and falls (`edge_sel` = 11), same stimulus, `ev_ready` = 1 → three events in order: rise t=1, fall t=7, rise t=8, each one cycle after its sampling edge.
- Overflow (DEPTH = 8, `ev_ready` = 0), 10 rise/fall toggles → `fill` = 8, `overflow` = 1, `drop_count` = 2. After `clear`, all three read 0 and `ev_valid` = 0.
- Full with simultaneous push and pop → no drop, `fill` stays 8, FIFO order preserved; the popped entry is the oldest timestamp.
- `enable` = 0 during a fall, then `enable` = 1 → no event logged and `ts` frozen. With no `a_in` change there is no spurious event afterwards, because `a_past` kept tracking.
- `rst_n` asserted asynchronously between clock edges with 3 queued events → `ev_valid` and `fill` go to 0 without waiting for a clock edge. After release, `a_in` = 1 at the first edge logs a rise with t=0.
